// File: rtl/key_scan_loader.sv
// Serial key loader with even-parity check and brute-force lockout for a logic-locked core.
// Status outputs (key_out/key_valid/key_error/fail_count/locked_out) sit one register behind the FSM.
module key_scan_loader #(
  parameter int                   KEY_WIDTH    = 16,
  parameter logic [KEY_WIDTH-1:0] DEFAULT_KEY  = '0,
  parameter int                   MAX_ATTEMPTS = 3,
  parameter bit                   RELOAD_EN    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 key_bit_in,
  input  logic                 key_bit_valid,
  output logic                 key_bit_ready,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 key_error,
  output logic                 locked_out,
  output logic [3:0]           fail_count
);

  localparam int CW = $clog2(KEY_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, DONE, ERROR, LOCKOUT} state_t;

  state_t               state_q, state_d;
  logic [KEY_WIDTH-1:0] shreg_q, shreg_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 parity_q, parity_d;
  logic                 valid_q, valid_d;
  logic                 error_q, error_d;
  logic [3:0]           fail_q, fail_d;
  logic                 accept;

  logic [KEY_WIDTH-1:0] key_out_q;
  logic                 key_valid_q, key_error_q, locked_q;
  logic [3:0]           fail_out_q;

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    parity_d      = parity_q;
    key_d         = key_q;
    valid_d       = valid_q;
    error_d       = error_q;
    fail_d        = fail_q;
    key_bit_ready = (state_q == SHIFT);
    accept        = key_bit_ready && key_bit_valid;

    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d   = SHIFT;
          shreg_d   = '0;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        // A restart request beats a bit arriving in the same cycle.
        if (load_start) begin
          shreg_d   = '0;
          bit_cnt_d = '0;
        end else if (accept) begin
          if (bit_cnt_q == CW'(KEY_WIDTH)) begin
            parity_d = key_bit_in;
            state_d  = CHECK;
          end else begin
            for (int i = 0; i < KEY_WIDTH; i++) begin
              if (bit_cnt_q == CW'(i)) shreg_d[i] = key_bit_in;
            end
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      CHECK: begin
        if ((^shreg_q ^ parity_q) == 1'b0) begin
          key_d   = shreg_q;
          valid_d = 1'b1;
          error_d = 1'b0;
          state_d = DONE;
        end else begin
          fail_d  = (fail_q >= 4'(MAX_ATTEMPTS)) ? fail_q : fail_q + 4'd1;
          error_d = 1'b1;
          if (fail_d == 4'(MAX_ATTEMPTS)) begin
            key_d   = DEFAULT_KEY;
            valid_d = 1'b0;
            state_d = LOCKOUT;
          end else begin
            state_d = ERROR;
          end
        end
      end
      DONE: begin
        // On reload the previous key stays live until a new one passes CHECK.
        if (RELOAD_EN && load_start) begin
          state_d   = SHIFT;
          shreg_d   = '0;
          bit_cnt_d = '0;
        end
      end
      ERROR: begin
        if (load_start) begin
          state_d   = SHIFT;
          shreg_d   = '0;
          bit_cnt_d = '0;
          error_d   = 1'b0;
        end
      end
      LOCKOUT: begin
        key_d   = DEFAULT_KEY;
        valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      parity_q    <= 1'b0;
      key_q       <= DEFAULT_KEY;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      fail_q      <= 4'd0;
      key_out_q   <= DEFAULT_KEY;
      key_valid_q <= 1'b0;
      key_error_q <= 1'b0;
      locked_q    <= 1'b0;
      fail_out_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      parity_q    <= parity_d;
      key_q       <= key_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
      fail_q      <= fail_d;
      key_out_q   <= key_q;
      key_valid_q <= valid_q;
      key_error_q <= error_q;
      locked_q    <= (state_q == LOCKOUT);
      fail_out_q  <= fail_q;
    end
  end

  assign key_out    = key_out_q;
  assign key_valid  = key_valid_q;
  assign key_error  = key_error_q;
  assign locked_out = locked_q;
  assign fail_count = fail_out_q;

endmodule

// File: tb/tb_key_scan_loader.sv
// Directed bench for key_scan_loader: a vector table of full transfers plus hand-written corner sequences.
module tb_key_scan_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic        kb = 1'b0;
  logic        kv = 1'b0;

  logic        rdy0, kvld0, kerr0, lock0;
  logic [15:0] key0;
  logic [3:0]  fc0;
  logic        rdy1, kvld1, kerr1, lock1;
  logic [15:0] key1;
  logic [3:0]  fc1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  key_scan_loader #(.KEY_WIDTH(16), .DEFAULT_KEY(16'h0), .MAX_ATTEMPTS(3), .RELOAD_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .load_start(load_start), .key_bit_in(kb), .key_bit_valid(kv),
    .key_bit_ready(rdy0), .key_out(key0), .key_valid(kvld0), .key_error(kerr0),
    .locked_out(lock0), .fail_count(fc0));

  key_scan_loader #(.KEY_WIDTH(16), .DEFAULT_KEY(16'h0), .MAX_ATTEMPTS(3), .RELOAD_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .load_start(load_start), .key_bit_in(kb), .key_bit_valid(kv),
    .key_bit_ready(rdy1), .key_out(key1), .key_valid(kvld1), .key_error(kerr1),
    .locked_out(lock1), .fail_count(fc1));

  typedef struct {
    logic        do_rst;
    logic [15:0] key;
    logic        par;
    logic [15:0] exp_key;
    logic        exp_vld;
    logic        exp_err;
    logic [3:0]  exp_fc;
    logic        exp_lock;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int gaps);
    repeat (gaps) begin
      kv = 1'b0;
      kb = 1'($urandom);
      tick();
    end
    kv = 1'b1;
    kb = b;
    tick();
    kv = 1'b0;
  endtask

  task automatic send_key(input logic [15:0] k, input logic p, input int maxgap);
    for (int i = 0; i < 16; i++) send_bit(k[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    send_bit(p, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 16'hA5C3, 1'b0, 16'hA5C3, 1'b1, 1'b0, 4'd0, 1'b0};
    vecs[1] = '{1'b1, 16'hA5C3, 1'b1, 16'h0000, 1'b0, 1'b1, 4'd1, 1'b0};
    vecs[2] = '{1'b0, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd2, 1'b0};
    vecs[3] = '{1'b0, 16'h1234, 1'b1, 16'h1234, 1'b1, 1'b0, 4'd2, 1'b0};
    vecs[4] = '{1'b1, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b1, 4'd1, 1'b0};
    vecs[5] = '{1'b0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd2, 1'b0};
    vecs[6] = '{1'b0, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd3, 1'b1};

    // Reset state
    do_rst();
    chk("rst_key", 32'(key0), 32'h0);
    chk("rst_ready", 32'(rdy0), 32'h0);
    chk("rst_valid", 32'(kvld0), 32'h0);
    chk("rst_error", 32'(kerr0), 32'h0);
    chk("rst_locked", 32'(lock0), 32'h0);
    chk("rst_fail", 32'(fc0), 32'h0);

    // Commit latency: valid exactly two edges after the parity accept
    start();
    chk("shift_ready", 32'(rdy0), 32'h1);
    send_key(16'hA5C3, 1'b0, 0);
    chk("check_ready", 32'(rdy0), 32'h0);
    tick();
    chk("lat_t1_valid", 32'(kvld0), 32'h0);
    chk("lat_t1_key", 32'(key0), 32'h0);
    tick();
    chk("lat_t2_valid", 32'(kvld0), 32'h1);
    chk("lat_t2_key", 32'(key0), 32'hA5C3);

    // Table of complete transfers, ending in lockout
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].do_rst) do_rst();
      start();
      send_key(vecs[v].key, vecs[v].par, 0);
      tick();
      tick();
      chk($sformatf("vec%0d_key", v), 32'(key0), 32'(vecs[v].exp_key));
      chk($sformatf("vec%0d_valid", v), 32'(kvld0), 32'(vecs[v].exp_vld));
      chk($sformatf("vec%0d_error", v), 32'(kerr0), 32'(vecs[v].exp_err));
      chk($sformatf("vec%0d_fail", v), 32'(fc0), 32'(vecs[v].exp_fc));
      chk($sformatf("vec%0d_locked", v), 32'(lock0), 32'(vecs[v].exp_lock));
      chk($sformatf("vec%0d_ready", v), 32'(rdy0), 32'h0);
    end

    // Lockout ignores a later good transfer; rst clears everything
    start();
    send_key(16'h1234, 1'b1, 0);
    tick();
    tick();
    chk("lock_key", 32'(key0), 32'h0);
    chk("lock_valid", 32'(kvld0), 32'h0);
    chk("lock_locked", 32'(lock0), 32'h1);
    chk("lock_fail", 32'(fc0), 32'h3);
    chk("lock_ready", 32'(rdy0), 32'h0);
    do_rst();
    chk("unlock_locked", 32'(lock0), 32'h0);
    chk("unlock_fail", 32'(fc0), 32'h0);
    chk("unlock_error", 32'(kerr0), 32'h0);

    // Bits outside SHIFT are ignored; abort after 7 bits; load_start beats a same-cycle bit
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    start();
    for (int i = 0; i < 7; i++) send_bit(1'b1, 0);
    start();
    chk("abort_key", 32'(key0), 32'h0);
    chk("abort_valid", 32'(kvld0), 32'h0);
    load_start = 1'b1;
    kv = 1'b1;
    kb = 1'b1;
    tick();
    load_start = 1'b0;
    kv = 1'b0;
    send_key(16'h1234, 1'b1, 0);
    tick();
    tick();
    chk("restart_key", 32'(key0), 32'h1234);
    chk("restart_valid", 32'(kvld0), 32'h1);
    chk("restart_error", 32'(kerr0), 32'h0);

    // rst mid-transfer leaves no partial key
    do_rst();
    start();
    for (int i = 0; i < 8; i++) send_bit(1'b1, 0);
    do_rst();
    chk("midrst_key", 32'(key0), 32'h0);
    chk("midrst_ready", 32'(rdy0), 32'h0);

    // Random gaps on key_bit_valid with junk data between beats
    start();
    send_key(16'h6B9D, 1'b0, 3);
    tick();
    tick();
    chk("gaps_key", 32'(key0), 32'h6B9D);
    chk("gaps_valid", 32'(kvld0), 32'h1);
    chk("gaps_key_r1", 32'(key1), 32'h6B9D);

    // Reload in DONE: ignored without RELOAD_EN, old key held until commit with it
    start();
    for (int i = 0; i < 8; i++) send_bit(logic'(16'hBEEF >> i), 0);
    chk("reload_mid_key1", 32'(key1), 32'h6B9D);
    chk("reload_mid_valid1", 32'(kvld1), 32'h1);
    chk("reload_mid_ready0", 32'(rdy0), 32'h0);
    chk("reload_mid_ready1", 32'(rdy1), 32'h1);
    for (int i = 8; i < 16; i++) send_bit(logic'(16'hBEEF >> i), 0);
    send_bit(1'b1, 0);
    tick();
    chk("reload_t1_key1", 32'(key1), 32'h6B9D);
    tick();
    chk("reload_key1", 32'(key1), 32'hBEEF);
    chk("reload_valid1", 32'(kvld1), 32'h1);
    chk("noreload_key0", 32'(key0), 32'h6B9D);
    chk("noreload_valid0", 32'(kvld0), 32'h1);
    chk("noreload_fail0", 32'(fc0), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
